// File: rtl/intersection_pkg.sv
// Shared types for the intersection scheduler: state encoding, lamp vectors
// and travel direction. Optional build macro: NIGHT_FLASH_EN adds FLASH (3'b111).
package intersection_pkg;

    // Fixed 3-bit encoding; 3'b111 is FLASH only in night-flash builds.
    typedef enum logic [2:0] {
        ALLRED_A  = 3'b000,
        NS_GREEN  = 3'b001,
        NS_YELLOW = 3'b010,
        ALLRED_B  = 3'b011,
        EW_GREEN  = 3'b100,
        EW_YELLOW = 3'b101,
`ifdef NIGHT_FLASH_EN
        PED_WALK  = 3'b110,
        FLASH     = 3'b111
`else
        PED_WALK  = 3'b110
`endif
    } state_t;

    // Lamp vectors ordered {red, yellow, green}.
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    typedef enum logic {NS = 1'b0, EW = 1'b1} dir_t;

endpackage

// File: rtl/intersection_ctrl_phase_timer.sv
// Loadable down-counter advanced only by the shared tick enable. It holds at
// zero, so a green phase with no opposing demand simply rests there.
module phase_timer #(
    parameter int              TW      = 4,
    parameter logic [TW-1:0]   RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          expire
);

    logic [TW-1:0] cnt;

    // Load wins over counting; decrement on tick, saturating at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     cnt <= RST_VAL;
        else if (load)               cnt <= load_val;
        else if (tick && cnt != '0)  cnt <= cnt - 1'b1;
    end

    assign expire = tick && (cnt == '0);

endmodule

// File: rtl/intersection_ctrl.sv
// Two-way intersection scheduler: NS/EW signal heads plus a pedestrian walk
// phase, phase lengths counted in ticks. Optional build macro: NIGHT_FLASH_EN
// adds the `night` input and a flashing-yellow/red FLASH mode.
module intersection_ctrl
    import intersection_pkg::*;
#(
    parameter int GREEN_TICKS  = 8,
    parameter int YELLOW_TICKS = 3,
    parameter int ALLRED_TICKS = 1,
    parameter int WALK_TICKS   = 5,
    parameter int TW           = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic car_ns,
    input  logic car_ew,
    input  logic ped_req,
`ifdef NIGHT_FLASH_EN
    input  logic night,
`endif
    output logic ns_red,
    output logic ns_yellow,
    output logic ns_green,
    output logic ew_red,
    output logic ew_yellow,
    output logic ew_green,
    output logic walk
);

    localparam int G_M1 = GREEN_TICKS - 1;
    localparam int Y_M1 = YELLOW_TICKS - 1;
    localparam int A_M1 = ALLRED_TICKS - 1;
    localparam int W_M1 = WALK_TICKS - 1;
    localparam logic [TW-1:0] G_LD = G_M1[TW-1:0];
    localparam logic [TW-1:0] Y_LD = Y_M1[TW-1:0];
    localparam logic [TW-1:0] A_LD = A_M1[TW-1:0];
    localparam logic [TW-1:0] W_LD = W_M1[TW-1:0];

    state_t        state, next_state;
    dir_t          last_dir;
    logic          ped_pending;
    logic          expire;
    logic          load;
    logic [TW-1:0] load_val;
    logic [2:0]    ns_lamp, ew_lamp;
`ifdef NIGHT_FLASH_EN
    logic          flash_on;
`endif

    phase_timer #(.TW(TW), .RST_VAL(A_LD)) u_timer (
        .clk      (clk),
        .rst      (reset),
        .tick     (tick),
        .load     (load),
        .load_val (load_val),
        .expire   (expire)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ALLRED_A;
        else       state <= next_state;
    end

    // Next-state selection and timer reload on every state change.
    always_comb begin
        next_state = state;
        case (state)
            ALLRED_A, ALLRED_B: if (expire)
                next_state = ped_pending ? PED_WALK :
                             (last_dir == NS) ? EW_GREEN : NS_GREEN;
            NS_GREEN:  if (expire && (car_ew || ped_pending)) next_state = NS_YELLOW;
            NS_YELLOW: if (expire) next_state = ALLRED_B;
            EW_GREEN:  if (expire && (car_ns || ped_pending)) next_state = EW_YELLOW;
            EW_YELLOW: if (expire) next_state = ALLRED_A;
            PED_WALK:  if (expire)
                next_state = (last_dir == NS) ? EW_GREEN : NS_GREEN;
`ifdef NIGHT_FLASH_EN
            FLASH:     if (!night) next_state = ALLRED_A;
`endif
            default:   next_state = ALLRED_A;
        endcase
`ifdef NIGHT_FLASH_EN
        // Greens drop straight into FLASH; other phases finish first.
        if (night && state != FLASH) begin
            if (state == NS_GREEN || state == EW_GREEN || expire)
                next_state = FLASH;
        end
`endif
        load = (next_state != state);
        case (next_state)
            NS_GREEN, EW_GREEN:   load_val = G_LD;
            NS_YELLOW, EW_YELLOW: load_val = Y_LD;
            PED_WALK:             load_val = W_LD;
            default:              load_val = A_LD;
        endcase
    end

    // ALLRED_B always follows NS service, ALLRED_A follows EW service (or a
    // recovery), so the direction just served is known from the all-red entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                               last_dir <= EW;
        else if (load && next_state == ALLRED_B) last_dir <= NS;
        else if (load && next_state == ALLRED_A) last_dir <= EW;
    end

    // Pedestrian latch; a request in the walk-entry cycle survives for next round.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                               ped_pending <= 1'b0;
        else if (ped_req)                        ped_pending <= 1'b1;
        else if (load && next_state == PED_WALK) ped_pending <= 1'b0;
    end

`ifdef NIGHT_FLASH_EN
    // Flash phase: lit on FLASH entry, toggles on each tick while flashing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)              flash_on <= 1'b1;
        else if (state != FLASH) flash_on <= 1'b1;
        else if (tick)          flash_on <= ~flash_on;
    end
`endif

    // Moore lamp decode from registered state only.
    always_comb begin
        ns_lamp = RED;
        ew_lamp = RED;
        walk    = 1'b0;
        case (state)
            NS_GREEN:  ns_lamp = GRN;
            NS_YELLOW: ns_lamp = YEL;
            EW_GREEN:  ew_lamp = GRN;
            EW_YELLOW: ew_lamp = YEL;
            PED_WALK:  walk    = 1'b1;
`ifdef NIGHT_FLASH_EN
            FLASH: begin
                ns_lamp = flash_on ? YEL : OFF;
                ew_lamp = flash_on ? RED : OFF;
            end
`endif
            default: ;
        endcase
    end

    assign {ns_red, ns_yellow, ns_green} = ns_lamp;
    assign {ew_red, ew_yellow, ew_green} = ew_lamp;

endmodule
